// File: rtl/riscv_pkg.sv
// riscv: shared rv32 types, ALU-class opcodes and the combinational decode function.
package riscv;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  shamt_t;

    // Encoded as {funct7[5], funct3} so legal OP encodings map directly.
    typedef enum logic [3:0] {
        FN_ADD  = 4'b0000,
        FN_SLL  = 4'b0001,
        FN_SLT  = 4'b0010,
        FN_SLTU = 4'b0011,
        FN_XOR  = 4'b0100,
        FN_SRL  = 4'b0101,
        FN_OR   = 4'b0110,
        FN_AND  = 4'b0111,
        FN_SUB  = 4'b1000,
        FN_SRA  = 4'b1101
    } funct_t;

    typedef enum logic [6:0] {
        OP     = 7'b0110011,
        OP_IMM = 7'b0010011,
        LUI    = 7'b0110111,
        AUIPC  = 7'b0010111
    } opcode_t;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        funct_t     funct;
        shamt_t     shamt;
        word_t      op1;
        word_t      op2;
        logic [4:0] rd;
        logic       wen;
        logic       illegal;
    } decoded_t;

    function automatic decoded_t decode_insn(word_t insn, word_t pc, word_t rs1, word_t rs2);
        decoded_t   d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       shift;
        logic       legal;
        f3    = insn[14:12];
        f7    = insn[31:25];
        shift = (f3 == F3_SLL) || (f3 == F3_SR);
        legal = 1'b1;
        d = '{funct: FN_ADD, shamt: '0, op1: '0, op2: '0, rd: insn[11:7], wen: 1'b0, illegal: 1'b0};
        case (insn[6:0])
            OP: begin
                legal   = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
                d.funct = funct_t'({f7[5], f3});
                d.op1   = rs1;
                d.op2   = rs2;
                d.shamt = shift ? rs2[4:0] : '0;
            end
            OP_IMM: begin
                legal   = !shift || (f7 == F7_BASE) || (f3 == F3_SR && f7 == F7_ALT);
                d.funct = funct_t'({shift & f7[5], f3});
                d.op1   = rs1;
                d.op2   = shift ? {27'b0, insn[24:20]} : {{20{insn[31]}}, insn[31:20]};
                d.shamt = shift ? insn[24:20] : '0;
            end
            LUI:     d.op2 = {insn[31:12], 12'b0};
            AUIPC: begin
                d.op1 = pc;
                d.op2 = {insn[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
        if (!legal)
            d = '{funct: FN_ADD, shamt: '0, op1: '0, op2: '0, rd: insn[11:7], wen: 1'b0, illegal: 1'b1};
        d.wen = legal && (insn[11:7] != 5'd0);
        return d;
    endfunction

    // Output register contents after reset: the decode of a NOP, never flagged illegal.
    function automatic decoded_t reset_decode(word_t insn);
        decoded_t d;
        d = decode_insn(insn, '0, '0, '0);
        d.illegal = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/decode_skid_buffer.sv
// skid_buffer: one-entry skid with registered upstream ready; data passes through when empty.
module skid_buffer #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic resetn,
    input  logic flush_i,
    input  logic in_valid_i,
    output logic in_ready_o,
    input  T     in_data_i,
    output logic out_valid_o,
    input  logic out_ready_i,
    output T     out_data_o
);
    logic full_q, full_d;
    T     data_q, data_d;

    assign in_ready_o  = !full_q;
    assign out_valid_o = full_q || in_valid_i;
    assign out_data_o  = full_q ? data_q : in_data_i;

    always_comb begin
        full_d = flush_i ? 1'b0 : full_q ? !out_ready_i : (in_valid_i && !out_ready_i);
        data_d = (!full_q && in_valid_i && !out_ready_i) ? in_data_i : data_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/decode.sv
// decode: RV32I ALU-class decode stage with a registered decoded_t output.
// DECODE_SKID_EN adds a skid buffer so in_ready no longer depends on out_ready.
module decode
    import riscv::*;
#(
    parameter word_t NOP_INSN = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  word_t      in_insn,
    input  word_t      in_pc,
    output logic [4:0] rs1_addr,
    output logic [4:0] rs2_addr,
    input  word_t      rs1_data,
    input  word_t      rs2_data,
    output logic       out_valid,
    input  logic       out_ready,
    output funct_t     out_funct,
    output shamt_t     out_shamt,
    output word_t      out_op1,
    output word_t      out_op2,
    output logic [4:0] out_rd,
    output logic       out_wen,
    output logic       out_illegal
);
    localparam decoded_t NOP_DEC = reset_decode(NOP_INSN);

    decoded_t dec, stage_data, dec_q, dec_d;
    logic     stage_valid, stage_ready, valid_q, valid_d;

    assign rs1_addr    = in_insn[19:15];
    assign rs2_addr    = in_insn[24:20];
    assign dec         = decode_insn(in_insn, in_pc, rs1_data, rs2_data);
    assign stage_ready = !valid_q || out_ready;

`ifdef DECODE_SKID_EN
    skid_buffer #(.T(decoded_t)) u_skid (
        .clk         (clk),
        .resetn      (resetn),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (dec),
        .out_valid_o (stage_valid),
        .out_ready_i (stage_ready),
        .out_data_o  (stage_data)
    );
`else
    assign in_ready    = stage_ready;
    assign stage_valid = in_valid;
    assign stage_data  = dec;
`endif

    always_comb begin
        valid_d = flush ? 1'b0 : stage_ready ? stage_valid : valid_q;
        dec_d   = (!flush && stage_ready && stage_valid) ? stage_data : dec_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            dec_q   <= NOP_DEC;
        end else begin
            valid_q <= valid_d;
            dec_q   <= dec_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_funct   = dec_q.funct;
    assign out_shamt   = dec_q.shamt;
    assign out_op1     = dec_q.op1;
    assign out_op2     = dec_q.op2;
    assign out_rd      = dec_q.rd;
    assign out_wen     = dec_q.wen;
    assign out_illegal = dec_q.illegal;
endmodule

// File: doc/decode.md
# decode

Instruction decode stage for the rv32cpu integer pipeline: accepts fetched RV32I instruction words on a valid/ready handshake and produces the registered operation, operands and destination that drive the ALU's funct, shamt, op1 and op2 inputs. It covers the ALU-class opcodes OP, OP-IMM, LUI and AUIPC, reads the register file combinationally, and flags every other encoding as illegal. It sits between fetch and execute.

## Interface
- NOP_INSN, default 32'h0000_0013: instruction assumed for the output register at reset (addi x0,x0,0); determines the out_* reset values.
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  discard in-flight decoded instructions
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  decode can accept
- in_insn  in  32  instruction word
- in_pc  in  32  address of in_insn
- rs1_addr, rs2_addr  out  5 each  in_insn[19:15], in_insn[24:20], combinational
- rs1_data, rs2_data  in  32 each  register file read data, same cycle
- out_valid  out  1  decoded instruction available
- out_ready  in  1  execute accepts
- out_funct  out  riscv::funct_t  ALU operation
- out_shamt  out  riscv::shamt_t  shift amount
- out_op1, out_op2  out  riscv::word_t  ALU operands
- out_rd  out  5  destination register
- out_wen  out  1  rd write enable
- out_illegal  out  1  unsupported encoding

## Operation
- OP: op1=rs1_data, op2=rs2_data. funct7 must be 0000000, except SUB and SRA, which require 0100000. Any other funct7/funct3 pairing is illegal.
- OP-IMM: op1=rs1_data, op2=sign-extended I-immediate.
  - SLLI and SRLI require imm[11:5]=0000000; SRAI requires 0100000.
  - For shifts, op2 = zero-extended insn[24:20].
- Register shifts: shamt = rs2_data[4:0]. Immediate shifts: shamt = insn[24:20]. Non-shifts: shamt = 0.
- LUI: funct ADD, op1=0, op2={insn[31:12],12'b0}.
- AUIPC: funct ADD, op1=in_pc, op2=U-immediate.
- Illegal (any other opcode or funct7): out_illegal=1, funct ADD, op1=op2=0, wen=0, rd still captured.
- out_wen = legal && rd!=0.

## Timing
- Latency 1 cycle: an input handshake (in_valid && in_ready) at edge N gives out_valid=1 with its fields after edge N. Throughput 1 instruction per cycle.
- Output transfer occurs on out_valid && out_ready.
- While out_valid && !out_ready, all out_* fields hold stable.
- Reset (asynchronous, any time, including mid-stall):
  - out_valid=0, out_illegal=0.
  - Other out_* fields take the NOP_INSN decode: ADD, op1=op2=0, shamt=0, rd=0, wen=0.
  - Skid entry cleared; in_ready=1 from the first edge after resetn rises.
- flush: at the next edge, out_valid=0 and the skid entry is dropped. An input handshake in the flush cycle completes but is discarded. Flush has priority over simultaneous input and output handshakes.
- Simultaneous output transfer and input handshake: the register is reloaded with no bubble.

## Configuration
- DECODE_SKID_EN defined:
  - A one-entry skid buffer sits in front of the output register.
  - in_ready is a register output (= skid empty), with no combinational path from out_ready.
  - An input accepted while the output stalls is held in the skid and moved to the output when it frees up; order is preserved.
- Undefined:
  - No skid buffer; in_ready = !out_valid || out_ready (combinational).
- Handshake-visible ordering and latency are identical in both configurations when out_ready stays high.

## Structure
- riscv package:
  - opcode_t enum (OP, OP_IMM, LUI, AUIPC);
  - funct3 and funct7 constants;
  - the existing funct_t, shamt_t and word_t types;
  - decoded_t struct (funct, shamt, op1, op2, rd, wen, illegal).
- Combinational decode is a function in the package. The module registers a decoded_t.
- One sub-module, skid_buffer (parameterised on type), instantiated only under DECODE_SKID_EN.

## Test plan
- Reset: assert resetn low during a stalled transfer → out_valid=0, out_funct=ADD, out_wen=0, in_ready=1 after release.
- 0xfff10093 (addi x1,x2,-1), rs1_data=5 → next cycle: ADD, op1=5, op2=0xffffffff, rd=1, wen=1.
- 0x40725193 (srai x3,x4,7) → SRA, op2=7, shamt=7. Then 0x407302b3 (sub x5,x6,x7), rs2_data=0x23 → SUB, op2=0x23, shamt=0.
- 0x123450b7 (lui x1,0x12345) → ADD, op1=0, op2=0x12345000. Then auipc x1,0x12345 at pc=0x100 → op1=0x100.
- Backpressure: four back-to-back ADDIs, out_ready low for 3 cycles → no loss or duplication, order preserved; in_ready matches the configured rule (run both with and without DECODE_SKID_EN).
- 0x02000033 (mul) → out_illegal=1, wen=0. Asserting flush with out_valid=1 → out_valid=0 next cycle and no output transfer.
